// File: rtl/cpu_key_driver.sv
// Computer-opponent key generator: emits a raw key level and one-cycle press pulse
// gated by an LFSR-vs-difficulty compare. Optional press counter via CPU_KEY_DRIVER_COUNT_EN.
module cpu_key_driver #(
  parameter int                LFSR_W      = 10,
  parameter int                HOLD_CYCLES = 3,
  parameter int                GAP_CYCLES  = 2,
  parameter logic [LFSR_W-1:0] SEED        = 10'h001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] difficulty,
`ifdef CPU_KEY_DRIVER_COUNT_EN
  output logic [7:0]        press_count,
`endif
  output logic              key_level,
  output logic              press_pulse,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESS   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              first;
  logic [LFSR_W-1:0] lfsr;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      first <= 1'b0;
      lfsr  <= SEED_SAFE;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[9] ^ lfsr[6]};
      case (state)
        IDLE: begin
          first <= 1'b0;
          if (enable && (lfsr < difficulty)) begin
            state <= PRESS;
            cnt   <= HOLD_LOAD;
            first <= 1'b1;
          end
        end
        PRESS: begin
          first <= 1'b0;
          // Losing enable ends the hold early but still runs the full gap.
          if (!enable || cnt == 4'd0) begin
            state <= RELEASE;
            cnt   <= GAP_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RELEASE: begin
          first <= 1'b0;
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          first <= 1'b0;
        end
      endcase
    end
  end

  assign key_level   = (state == PRESS);
  assign press_pulse = (state == PRESS) && first;
  assign busy        = (state == PRESS) || (state == RELEASE);

`ifdef CPU_KEY_DRIVER_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                   press_count <= '0;
    else if (press_pulse && press_count != 8'hFF) press_count <= press_count + 8'd1;
  end
`endif

endmodule
